// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction memory port, pipeline control, branch training
// inputs and the registered IF/ID outputs. The fetch stage uses the master modport.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bp_update;
  logic [31:0] bp_pc;
  logic [31:0] bp_target;
  logic        bp_taken;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_pred_taken;

  modport master (
    output imem_addr, if_id_valid, if_id_pc, if_id_inst, if_id_pred_taken,
    input  imem_dout, stall, redirect_valid, redirect_pc,
           bp_update, bp_pc, bp_target, bp_taken
  );

  modport slave (
    input  imem_addr, if_id_valid, if_id_pc, if_id_inst, if_id_pred_taken,
    output imem_dout, stall, redirect_valid, redirect_pc,
           bp_update, bp_pc, bp_target, bp_taken
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and an optional
// direct-mapped branch target buffer compiled in by the FETCH_BTB_EN macro.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        if_pred_q;
  logic        pred_taken;
  logic [31:0] pred_target;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [31:0]      btb_target_q [BTB_ENTRIES];
  logic [1:0]       btb_ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic [3:0]       unused_ok;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[31:IDX_W+2];
  assign up_idx = bus.bp_pc[IDX_W+1:2];
  assign up_tag = bus.bp_pc[31:IDX_W+2];
  assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  assign pred_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag)
                       && btb_ctr_q[lk_idx][1];
  assign pred_target = btb_target_q[lk_idx] & 32'hFFFF_FFFC;
  assign unused_ok   = {bus.bp_pc[1:0], bus.redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_ctr_q[i]    <= 2'b01;
      end
    end else if (bus.bp_update) begin
      btb_target_q[up_idx] <= bus.bp_target;
      if (!up_hit) begin
        btb_valid_q[up_idx] <= 1'b1;
        btb_tag_q[up_idx]   <= up_tag;
        btb_ctr_q[up_idx]   <= bus.bp_taken ? 2'b10 : 2'b01;
      end else if (bus.bp_taken && btb_ctr_q[up_idx] != 2'b11) begin
        btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'b01;
      end else if (!bus.bp_taken && btb_ctr_q[up_idx] != 2'b00) begin
        btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'b01;
      end
    end
  end
`else
  logic unused_ok;

  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
  assign unused_ok   = ^{bus.bp_update, bus.bp_pc, bus.bp_target, bus.bp_taken,
                         bus.redirect_pc[1:0]};
`endif

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (!bus.stall) begin
      pc_d = pred_taken ? pred_target : pc_plus4;
    end
  end

  // Redirect flushes IF/ID but leaves if_id_pc as-is; valid=0 marks it stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= {RESET_PC[31:2], 2'b00};
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP;
      if_pred_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (bus.redirect_valid) begin
        if_valid_q <= 1'b0;
        if_inst_q  <= NOP;
        if_pred_q  <= 1'b0;
      end else if (!bus.stall) begin
        if_valid_q <= 1'b1;
        if_pc_q    <= pc_q;
        if_inst_q  <= bus.imem_dout;
        if_pred_q  <= pred_taken;
      end
    end
  end

  assign bus.imem_addr        = pc_q;
  assign bus.if_id_valid      = if_valid_q;
  assign bus.if_id_pc         = if_pc_q;
  assign bus.if_id_inst       = if_inst_q;
  assign bus.if_id_pred_taken = if_pred_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a behavioural model of PC sequencing and BTB training.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          BTB_N    = 16;
`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .BTB_ENTRIES(BTB_N)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign bus.imem_dout = mem[bus.imem_addr[7:2]];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc, m_ifpc, m_inst;
  logic        m_valid, m_pred;
  bit          mv   [BTB_N];
  int unsigned mtag [BTB_N];
  logic [31:0] mtgt [BTB_N];
  int          mctr [BTB_N];

  task automatic idle();
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.bp_update = 0; bus.bp_pc = 0; bus.bp_target = 0; bus.bp_taken = 0;
  endtask

  // Advance model by one edge using the currently driven inputs, then the DUT.
  task automatic cycle();
    int          ix, ux;
    bit          pt;
    logic [31:0] nxt;
    ix  = int'((m_pc >> 2) % BTB_N);
    pt  = BTB_ON && mv[ix] && (mtag[ix] == (m_pc >> 2) / BTB_N) && (mctr[ix] >= 2);
    nxt = pt ? (mtgt[ix] & 32'hFFFF_FFFC) : m_pc + 32'd4;
    if (reset) begin
      m_pc = RESET_PC; m_valid = 0; m_ifpc = 0; m_inst = 32'h13; m_pred = 0;
      for (int i = 0; i < BTB_N; i++) begin mv[i] = 0; mctr[i] = 1; end
    end else begin
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc & 32'hFFFF_FFFC; m_valid = 0; m_inst = 32'h13; m_pred = 0;
      end else if (!bus.stall) begin
        m_inst = mem[m_pc[7:2]]; m_ifpc = m_pc; m_valid = 1; m_pred = pt; m_pc = nxt;
      end
      if (bus.bp_update) begin
        ux = int'((bus.bp_pc >> 2) % BTB_N);
        mtgt[ux] = bus.bp_target;
        if (!mv[ux] || mtag[ux] != (bus.bp_pc >> 2) / BTB_N) begin
          mv[ux] = 1; mtag[ux] = (bus.bp_pc >> 2) / BTB_N;
          mctr[ux] = bus.bp_taken ? 2 : 1;
        end else if (bus.bp_taken) begin
          mctr[ux] = (mctr[ux] < 3) ? mctr[ux] + 1 : 3;
        end else begin
          mctr[ux] = (mctr[ux] > 0) ? mctr[ux] - 1 : 0;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    cycle(); cycle();
    n_checks++; if (bus.imem_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_inst !== 32'h13) begin n_errors++; $display("FAIL reset_inst got=%h exp=00000013", bus.if_id_inst); end
    n_checks++; if (bus.if_id_pc !== 32'h0) begin n_errors++; $display("FAIL reset_ifpc got=%h exp=0", bus.if_id_pc); end
    n_checks++; if (bus.if_id_pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred got=%b exp=0", bus.if_id_pred_taken); end
  endtask

  task automatic test_sequential();
    reset = 0;
    cycle();
    n_checks++; if (bus.imem_addr !== 32'h4) begin n_errors++; $display("FAIL seq_addr1 got=%h exp=4", bus.imem_addr); end
    n_checks++; if (bus.if_id_valid !== 1'b1) begin n_errors++; $display("FAIL seq_valid got=%b exp=1", bus.if_id_valid); end
    n_checks++; if (bus.if_id_inst !== mem[0]) begin n_errors++; $display("FAIL seq_instA got=%h exp=%h", bus.if_id_inst, mem[0]); end
    cycle();
    n_checks++; if (bus.imem_addr !== 32'h8) begin n_errors++; $display("FAIL seq_addr2 got=%h exp=8", bus.imem_addr); end
    n_checks++; if (bus.if_id_inst !== mem[1]) begin n_errors++; $display("FAIL seq_instB got=%h exp=%h", bus.if_id_inst, mem[1]); end
    n_checks++; if (bus.if_id_pc !== 32'h4) begin n_errors++; $display("FAIL seq_ifpc got=%h exp=4", bus.if_id_pc); end
  endtask

  task automatic test_stall();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (bus.imem_addr !== 32'h8) begin n_errors++; $display("FAIL stall_addr[%0d] got=%h exp=8", i, bus.imem_addr); end
      n_checks++; if (bus.if_id_inst !== mem[1]) begin n_errors++; $display("FAIL stall_inst[%0d] got=%h exp=%h", i, bus.if_id_inst, mem[1]); end
    end
    bus.stall = 0;
    cycle();
    n_checks++; if (bus.if_id_inst !== mem[2]) begin n_errors++; $display("FAIL stall_resume_inst got=%h exp=%h", bus.if_id_inst, mem[2]); end
    n_checks++; if (bus.imem_addr !== 32'hC) begin n_errors++; $display("FAIL stall_resume_addr got=%h exp=c", bus.imem_addr); end
  endtask

  task automatic test_redirect_stall();
    bus.stall = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
    cycle();
    n_checks++; if (bus.imem_addr !== 32'h40) begin n_errors++; $display("FAIL redir_addr got=%h exp=40", bus.imem_addr); end
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_errors++; $display("FAIL redir_valid got=%b exp=0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_inst !== 32'h13) begin n_errors++; $display("FAIL redir_inst got=%h exp=00000013", bus.if_id_inst); end
    idle();
    cycle();
    n_checks++; if (bus.if_id_inst !== mem[16] || bus.if_id_pc !== 32'h40) begin n_errors++; $display("FAIL redir_fetch got=%h@%h exp=%h@40", bus.if_id_inst, bus.if_id_pc, mem[16]); end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFF;
    cycle();
    n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_align got=%h exp=fffffffc", bus.imem_addr); end
    idle();
    cycle();
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_addr got=%h exp=0", bus.imem_addr); end
    n_checks++; if (bus.if_id_pc !== 32'hFFFF_FFFC || bus.if_id_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_ifid got=%h/%b exp=fffffffc/1", bus.if_id_pc, bus.if_id_valid); end
  endtask

  task automatic test_btb();
    logic [31:0] exp_addr;
    bus.bp_update = 1; bus.bp_pc = 32'h10; bus.bp_target = 32'h80; bus.bp_taken = 1;
    bus.redirect_valid = 1; bus.redirect_pc = 32'h10;
    cycle();
    idle();
    cycle();
    exp_addr = BTB_ON ? 32'h80 : 32'h14;
    n_checks++; if (bus.imem_addr !== exp_addr) begin n_errors++; $display("FAIL btb_taken_addr got=%h exp=%h", bus.imem_addr, exp_addr); end
    n_checks++; if (bus.if_id_pred_taken !== BTB_ON) begin n_errors++; $display("FAIL btb_taken_pred got=%b exp=%b", bus.if_id_pred_taken, BTB_ON); end
    bus.bp_update = 1; bus.bp_pc = 32'h10; bus.bp_target = 32'h80; bus.bp_taken = 0;
    cycle(); cycle();
    idle(); bus.redirect_valid = 1; bus.redirect_pc = 32'h10;
    cycle();
    idle();
    cycle();
    n_checks++; if (bus.imem_addr !== 32'h14) begin n_errors++; $display("FAIL btb_nt_addr got=%h exp=14", bus.imem_addr); end
    n_checks++; if (bus.if_id_pred_taken !== 1'b0) begin n_errors++; $display("FAIL btb_nt_pred got=%b exp=0", bus.if_id_pred_taken); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_addr;
    bus.bp_update = 1; bus.bp_pc = 32'h10; bus.bp_target = 32'h80; bus.bp_taken = 1;
    cycle(); cycle();
    idle(); bus.redirect_valid = 1; bus.redirect_pc = 32'h10;
    cycle();
    idle();
    cycle();
    exp_addr = BTB_ON ? 32'h80 : 32'h14;
    n_checks++; if (bus.imem_addr !== exp_addr) begin n_errors++; $display("FAIL mid_trained got=%h exp=%h", bus.imem_addr, exp_addr); end
    reset = 1; bus.stall = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h60;
    cycle();
    idle(); reset = 0;
    n_checks++; if (bus.imem_addr !== RESET_PC || bus.if_id_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset got=%h/%b exp=%h/0", bus.imem_addr, bus.if_id_valid, RESET_PC); end
    bus.redirect_valid = 1; bus.redirect_pc = 32'h10;
    cycle();
    idle();
    cycle();
    n_checks++; if (bus.imem_addr !== 32'h14 || bus.if_id_pred_taken !== 1'b0) begin n_errors++; $display("FAIL mid_cleared got=%h/%b exp=14/0", bus.imem_addr, bus.if_id_pred_taken); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset              = ($urandom_range(0, 99) < 2);
      bus.stall          = ($urandom_range(0, 99) < 30);
      bus.redirect_valid = ($urandom_range(0, 99) < 10);
      bus.redirect_pc    = 32'($urandom_range(0, 255));
      bus.bp_update      = ($urandom_range(0, 99) < 40);
      bus.bp_pc          = 32'($urandom_range(0, 255));
      bus.bp_target      = 32'($urandom_range(0, 63)) << 2;
      bus.bp_taken       = 1'($urandom_range(0, 1));
      cycle();
      n_checks++; if (bus.imem_addr !== m_pc) begin n_errors++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, bus.imem_addr, m_pc); end
      n_checks++; if (bus.if_id_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.if_id_valid, m_valid); end
      n_checks++; if (bus.if_id_pc !== m_ifpc) begin n_errors++; $display("FAIL rnd_ifpc[%0d] got=%h exp=%h", i, bus.if_id_pc, m_ifpc); end
      n_checks++; if (bus.if_id_inst !== m_inst) begin n_errors++; $display("FAIL rnd_inst[%0d] got=%h exp=%h", i, bus.if_id_inst, m_inst); end
      n_checks++; if (bus.if_id_pred_taken !== m_pred) begin n_errors++; $display("FAIL rnd_pred[%0d] got=%b exp=%b", i, bus.if_id_pred_taken, m_pred); end
    end
    reset = 0; idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    for (int i = 0; i < BTB_N; i++) begin mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1; end
    m_pc = RESET_PC; m_ifpc = 0; m_inst = 32'h13; m_valid = 0; m_pred = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_btb();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the address of the first fetch after reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16 (power of two), the number of branch target buffer entries.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  fetch address driven to the instruction memory.
REQ-006 SHALL have port imem_dout  input  32  instruction returned combinationally for imem_addr.
REQ-007 SHALL have port stall  input  1  the decode stage cannot accept; hold the PC and the IF/ID register.
REQ-008 SHALL have port redirect_valid  input  1  the execute stage reports a mispredict or jump.
REQ-009 SHALL have port redirect_pc  input  32  the correct next PC when redirect_valid is high.
REQ-010 SHALL have ports bp_update (1), bp_pc (32), bp_target (32) and bp_taken (1), all inputs, forming the resolved-branch training interface.
REQ-011 SHALL have outputs if_id_valid (1), if_id_pc (32), if_id_inst (32) and if_id_pred_taken (1), all registered.

Function
REQ-012 imem_addr SHALL equal the PC register combinationally; there is no other path from any input to imem_addr.
REQ-013 With no stall and no redirect, each edge SHALL load the IF/ID register as follows:
- if_id_inst <= imem_dout
- if_id_pc <= PC
- if_id_valid <= 1
- if_id_pred_taken <= the prediction for PC
- PC <= predicted next PC
REQ-014 Predicted next PC SHALL be PC+4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h0, unless the BTB predicts taken, in which case it SHALL be the BTB target.
REQ-015 With stall high and redirect_valid low, the PC and all IF/ID outputs SHALL hold their values.
REQ-016 With redirect_valid high, the next edge SHALL apply the flush below regardless of stall; redirect has priority over stall.
- PC <= redirect_pc
- if_id_valid <= 0
- if_id_inst <= 32'h00000013 (NOP)
- if_id_pred_taken <= 0
REQ-017 When the fetch stage is not flushed, latency SHALL be one cycle: the instruction at address A appears on if_id_inst on the edge after imem_addr equals A.
REQ-018 PC bits [1:0] SHALL always be 0; redirect_pc[1:0] SHALL be ignored (forced to 0).

Reset
REQ-019 Reset high at an edge SHALL apply the following and SHALL override stall, redirect and bp_update, including when asserted mid-operation:
- PC <= RESET_PC
- if_id_valid <= 0
- if_id_pc <= 0
- if_id_inst <= 32'h00000013
- if_id_pred_taken <= 0
- all BTB entries invalid, all counters set to 2'b01
REQ-020 The first valid fetch SHALL be from RESET_PC, on the first edge with reset low.

Configuration
REQ-021 Macro FETCH_BTB_EN SHALL compile in a direct-mapped BTB with BTB_ENTRIES entries.
- Index: PC[log2(BTB_ENTRIES)+1:2]; tag: the remaining upper PC bits.
- Each entry holds a valid bit, tag, 32-bit target and a 2-bit saturating counter.
- Predict taken when the entry is valid, the tag matches and counter >= 2'b10.
REQ-022 With FETCH_BTB_EN defined, bp_update high at an edge SHALL train the entry selected by bp_pc.
- On a tag mismatch or invalid entry: write tag and target, set valid, set the counter to 2'b10 if bp_taken else 2'b01.
- On a tag match: write target, increment the counter (saturating at 2'b11) if bp_taken, else decrement it (saturating at 2'b00).
- The update is visible to a lookup in the following cycle, not the same cycle.
REQ-023 With FETCH_BTB_EN undefined, no BTB SHALL exist and:
- predicted next PC is always PC+4;
- if_id_pred_taken is constant 0;
- the bp_* ports remain present and are ignored.

Verification
REQ-024 Reset with RESET_PC=0 and memory word0=A, word1=B, then release: imem_addr is 0, then 4, then 8; if_id_inst is A, then B; if_id_valid rises on the first edge after release.
REQ-025 Stall for 3 cycles while if_id_inst=B: imem_addr stays 8 and if_id_inst stays B for 3 cycles, then fetching resumes at word 2.
REQ-026 redirect_valid=1 with redirect_pc=32'h40 and stall=1 on the same edge: the next cycle has imem_addr=32'h40, if_id_valid=0 and if_id_inst=32'h13.
REQ-027 PC forced to 32'hFFFFFFFC via redirect: the next fetch address is 32'h0 with no error.
REQ-028 With FETCH_BTB_EN: bp_update with bp_pc=32'h10, bp_target=32'h80 and bp_taken=1, then fetch 32'h10: the next imem_addr is 32'h80 and if_id_pred_taken=1. Two subsequent not-taken updates: the next fetch of 32'h10 is followed by 32'h14.
REQ-029 Assert reset mid-stream with a trained BTB: the next cycle has imem_addr=RESET_PC and if_id_valid=0, and a fetch of 32'h10 then predicts not-taken.
